// File: rtl/multicycle_ctrl_fsm_pkg.sv
// multicycle_ctrl_fsm_pkg: opcodes, state encoding and control-word decode for the multicycle control unit
package ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] I_LOAD = 7'b0000011;
    localparam logic [6:0] S_TYPE = 7'b0100011;
    localparam logic [6:0] B_TYPE = 7'b1100011;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    localparam logic [2:0] BEQ = 3'b000;
    localparam logic [2:0] BNE = 3'b001;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_EXECU, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_TRAP
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       trap;
        logic       busy;
    } ctl_t;

    function automatic state_t decode_next(input logic [6:0] op);
        case (op)
            I_LOAD, S_TYPE: return S_MEMADR;
            R_TYPE:         return S_EXECR;
            I_TYPE:         return S_EXECI;
            AUIPC, LUI:     return S_EXECU;
            B_TYPE:         return S_BRANCH;
            JAL:            return S_JAL;
            JALR:           return S_JALR;
            default:        return S_TRAP;
        endcase
    endfunction

    // pc_write in FETCH/BRANCH and ir_write are qualified outside this table
    function automatic ctl_t state_ctl(input state_t s, input logic [6:0] op);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.adr_src  = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_MEM;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALU_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_FUNCT;
            end
            S_EXECU: begin
                c.alu_src_a = (op == LUI) ? SRCA_ZERO : SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_BRANCH: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALU_SUB;
            end
            S_JAL: begin
                c.pc_write  = 1'b1;
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
            end
            S_JALR: begin
                c.pc_write   = 1'b1;
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_IMM;
                c.result_src = RES_ALU;
            end
            S_TRAP: c.trap = 1'b1;
            default: ;
        endcase
        c.busy = !(s == S_FETCH || s == S_TRAP);
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// multicycle_ctrl_fsm_if: instruction fields, memory handshake and datapath controls (instret with CTRL_PERF_CNT_EN)
interface multicycle_ctrl_fsm_if #(
    parameter int ALUOP_W = 2
);
    logic [6:0]         opcode;
    logic [2:0]         func3;
    logic               zero;
    logic               mem_ready;
    logic               pc_write;
    logic               ir_write;
    logic               adr_src;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         result_src;
    logic               trap;
    logic               busy;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0]        instret;
`endif

    modport master (
        input  opcode, func3, zero, mem_ready,
        output pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, trap, busy
`ifdef CTRL_PERF_CNT_EN
        , output instret
`endif
    );

    modport slave (
        output opcode, func3, zero, mem_ready,
        input  pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, trap, busy
`ifdef CTRL_PERF_CNT_EN
        , input instret
`endif
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// mem_wait_timer: counts consecutive memory wait cycles and flags the last allowed one
module mem_wait_timer #(
    parameter int CNT_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // clear wins over counting so every new wait state starts from zero
    always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;

    // wait counter register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

    // this waiting cycle would be the MEM_TIMEOUT-th one
    assign timeout = cnt_q == CNT_W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: RV32I multicycle control FSM; CTRL_PERF_CNT_EN adds the instret counter
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input logic                   clk,
    input logic                   reset,
    multicycle_ctrl_fsm_if.master bus
);
    state_t state_q, state_d;
    ctl_t   ctl_q, ctl_d, ctl_o;
    logic   mem_ready, timeout, waiting, br_take;

    assign mem_ready = bus.mem_ready;
    assign waiting   = state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE};

    mem_wait_timer #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_d != state_q),
        .en      (waiting && !mem_ready),
        .timeout (timeout)
    );

    // next state; mem_ready beats a timeout landing in the same cycle
    always_comb begin
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : timeout ? S_TRAP : S_FETCH;
            S_DECODE:   state_d = decode_next(bus.opcode);
            S_MEMADR:   state_d = (bus.opcode == I_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : timeout ? S_TRAP : S_MEMREAD;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : timeout ? S_TRAP : S_MEMWRITE;
            S_MEMWB:    state_d = S_FETCH;
            S_ALUWB:    state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_EXECU:    state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_ALUWB;
            S_BRANCH:   state_d = (bus.func3 == BEQ || bus.func3 == BNE) ? S_FETCH : S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    // control word for the coming state, so outputs leave a flop
    always_comb ctl_d = state_ctl(state_d, bus.opcode);

    // state and registered Moore outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctl_q   <= state_ctl(S_FETCH, bus.opcode);
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
        end
    end

    assign br_take = (bus.func3 == BEQ && bus.zero) || (bus.func3 == BNE && !bus.zero);
    assign ctl_o   = reset ? '0 : ctl_q;

    assign bus.pc_write   = !reset && (state_q == S_FETCH  ? mem_ready :
                                       state_q == S_BRANCH ? br_take : ctl_o.pc_write);
    assign bus.ir_write   = !reset && state_q == S_FETCH && mem_ready;
    assign bus.adr_src    = ctl_o.adr_src;
    assign bus.mem_read   = ctl_o.mem_read;
    assign bus.mem_write  = ctl_o.mem_write;
    assign bus.reg_write  = ctl_o.reg_write;
    assign bus.alu_src_a  = ctl_o.alu_src_a;
    assign bus.alu_src_b  = ctl_o.alu_src_b;
    assign bus.alu_op     = ALUOP_W'(ctl_o.alu_op);
    assign bus.result_src = ctl_o.result_src;
    assign bus.trap       = ctl_o.trap;
    assign bus.busy       = ctl_o.busy;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instret_q, instret_d;

    // one retirement per return to FETCH from a completing state
    always_comb instret_d = instret_q + 32'(state_d == S_FETCH &&
                                            state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH});

    // retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) instret_q <= '0;
        else instret_q <= instret_d;
    end

    assign bus.instret = instret_q;
`endif
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: randomized instruction stream scored cycle by cycle against a sequence model
module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam int         TMO      = 15;

    typedef struct {
        logic [15:0] v;
        logic [31:0] ir;
        bit          chk_ir;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.ALUOP_W(2)) bus ();

    multicycle_ctrl_fsm #(.ALUOP_W(2), .MEM_TIMEOUT(TMO), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] ret = 0;
    logic [6:0]  op_n = OP_R;
    logic [2:0]  f3_n = 3'd0;
    logic [15:0] fw_v, fg_v, dec_v, madr_v, mrd_v, mwb_v, mwr_v, exr_v, exi_v, aui_v, lui_v, awb_v, jal_v, jalr_v, trp_v;

    // control vector: {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, alu_src_a, alu_src_b, alu_op, result_src, trap, busy}
    function automatic logic [15:0] cv(input bit pcw, irw, adr, mr, mw, rw,
                                       input logic [1:0] a, b, op, rs, input bit tr, bz);
        return {pcw, irw, adr, mr, mw, rw, a, b, op, rs, tr, bz};
    endfunction

    function automatic logic [15:0] br_v(input bit taken);
        return cv(taken, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 0, 1);
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit legal(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LW, OP_SW, OP_B, OP_AUIPC, OP_LUI, OP_JAL, OP_JALR};
    endfunction

    // drive one cycle and queue what the outputs must show during it
    task automatic cyc(input bit r, input bit mr, input bit zr, input logic [15:0] v,
                       input string nm, input bit retire);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r;
        bus.mem_ready = mr;
        bus.zero = zr;
        bus.opcode = op_n;
        bus.func3 = f3_n;
        e.v = v;
        e.ir = ret;
        e.chk_ir = !r;
        e.nm = nm;
        exp_q.push_back(e);
        if (r) ret = 0;
        else if (retire) ret = ret + 1;
    endtask

    task automatic one(input logic [15:0] v, input string nm, input bit rt);
        cyc(0, rb(), rb(), v, nm, rt);
    endtask

    task automatic do_reset();
        cyc(1, rb(), rb(), 16'h0, "reset", 0);
    endtask

    task automatic fetch(input int w);
        for (int i = 0; i < w; i++) cyc(0, 0, rb(), fw_v, "fetch_wait", 0);
        cyc(0, 1, rb(), fg_v, "fetch_go", 0);
    endtask

    task automatic mem_phase(input int w, input logic [15:0] v, input string nm, input bit rt);
        for (int i = 0; i < w; i++) cyc(0, 0, rb(), v, nm, 0);
        cyc(0, 1, rb(), v, nm, rt);
    endtask

    task automatic trapped(input int n);
        for (int i = 0; i < n; i++) one(trp_v, "trap", 0);
    endtask

    task automatic branch_instr(input logic [2:0] f3, input bit z, input int wf);
        op_n = OP_B;
        f3_n = f3;
        fetch(wf);
        one(dec_v, "decode", 0);
        cyc(0, rb(), z, br_v(f3 == 3'b000 ? z : !z), "branch", 1);
    endtask

    task automatic bad_branch(input logic [2:0] f3);
        op_n = OP_B;
        f3_n = f3;
        fetch(0);
        one(dec_v, "decode", 0);
        cyc(0, rb(), rb(), br_v(0), "branch_bad", 0);
        trapped(3);
        do_reset();
    endtask

    task automatic illegal_op(input logic [6:0] op, input int n);
        op_n = op;
        fetch($urandom_range(0, 2));
        one(dec_v, "decode_bad", 0);
        trapped(n);
        do_reset();
    endtask

    task automatic instr(input int kind, input int wf, input int wm);
        case (kind)
            0: op_n = OP_R;
            1: op_n = OP_I;
            2: op_n = OP_AUIPC;
            3: op_n = OP_LUI;
            4: op_n = OP_LW;
            5: op_n = OP_SW;
            7: op_n = OP_JAL;
            default: op_n = OP_JALR;
        endcase
        f3_n = 3'($urandom_range(0, 7));
        if (kind == 6) begin
            branch_instr(3'($urandom_range(0, 1)), rb(), wf);
        end else begin
            fetch(wf);
            one(dec_v, "decode", 0);
            case (kind)
                0: begin one(exr_v, "execr", 0); one(awb_v, "aluwb", 1); end
                1: begin one(exi_v, "execi", 0); one(awb_v, "aluwb", 1); end
                2: begin one(aui_v, "auipc", 0); one(awb_v, "aluwb", 1); end
                3: begin one(lui_v, "lui", 0); one(awb_v, "aluwb", 1); end
                4: begin
                    one(madr_v, "memadr", 0);
                    mem_phase(wm, mrd_v, "memread", 0);
                    one(mwb_v, "memwb", 1);
                end
                5: begin
                    one(madr_v, "memadr", 0);
                    mem_phase(wm, mwr_v, "memwrite", 1);
                end
                7: begin one(jal_v, "jal", 0); one(awb_v, "aluwb", 1); end
                default: begin one(jalr_v, "jalr", 0); one(awb_v, "aluwb", 1); end
            endcase
        end
    endtask

    // monitor: each cycle compare the DUT outputs with the oldest queued expectation
    initial begin
        exp_t        e;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {bus.pc_write, bus.ir_write, bus.adr_src, bus.mem_read, bus.mem_write,
                       bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src,
                       bus.trap, bus.busy};
                checks++;
                if (act !== e.v) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b at %0t", e.nm, act, e.v, $time);
                end
`ifdef CTRL_PERF_CNT_EN
                if (e.chk_ir) begin
                    checks++;
                    if (bus.instret !== e.ir) begin
                        errors++;
                        $display("FAIL instret in %s: got %0d expected %0d at %0t", e.nm, bus.instret, e.ir, $time);
                    end
                end
`endif
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        fw_v   = cv(0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
        fg_v   = cv(1, 1, 0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0);
        dec_v  = cv(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 1);
        madr_v = cv(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 1);
        mrd_v  = cv(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);
        mwb_v  = cv(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 0, 1);
        mwr_v  = cv(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);
        exr_v  = cv(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 1);
        exi_v  = cv(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 0, 1);
        aui_v  = cv(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b10, 2'b00, 0, 1);
        lui_v  = cv(0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b10, 2'b00, 0, 1);
        awb_v  = cv(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);
        jal_v  = cv(1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0, 1);
        jalr_v = cv(1, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b10, 0, 1);
        trp_v  = cv(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        bus.opcode = OP_R;
        bus.func3 = 3'd0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        do_reset();
        instr(0, 0, 0);
        instr(4, 0, 3);
        branch_instr(3'b000, 1, 0);
        branch_instr(3'b001, 1, 0);
        branch_instr(3'b001, 0, 1);
        bad_branch(3'b100);
        illegal_op(7'b0000000, 20);
        op_n = OP_R;
        for (int i = 0; i < TMO; i++) cyc(0, 0, rb(), fw_v, "fetch_timeout", 0);
        trapped(3);
        do_reset();
        instr(0, TMO - 1, 0);
        op_n = OP_LW;
        fetch(0);
        one(dec_v, "decode", 0);
        one(madr_v, "memadr", 0);
        for (int i = 0; i < TMO; i++) cyc(0, 0, rb(), mrd_v, "memread_timeout", 0);
        trapped(2);
        do_reset();
        instr(4, 0, TMO - 1);
        instr(5, 1, TMO - 1);
        do_reset();
        instr(0, 0, 0);
        instr(0, 0, 0);
        instr(0, 0, 0);
        instr(5, 0, 0);
        op_n = OP_LW;
        fetch(1);
        one(dec_v, "decode", 0);
        one(madr_v, "memadr", 0);
        cyc(0, 0, rb(), mrd_v, "memread", 0);
        cyc(0, 0, rb(), mrd_v, "memread", 0);
        do_reset();
        for (int n = 0; n < 200; n++) begin
            k = $urandom_range(0, 19);
            if (k == 18) begin
                logic [6:0] op;
                do op = 7'($urandom); while (legal(op));
                illegal_op(op, $urandom_range(1, 4));
            end else if (k == 19) begin
                bad_branch(3'($urandom_range(2, 7)));
            end else begin
                instr(k % 9,
                      ($urandom_range(0, 7) == 0) ? $urandom_range(3, TMO - 1) : $urandom_range(0, 2),
                      ($urandom_range(0, 7) == 0) ? $urandom_range(3, TMO - 1) : $urandom_range(0, 2));
            end
        end
        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multicycle control unit for the RV32I core; replaces the single-cycle combinational main decoder.
- Sequences fetch / decode / execute / memory / writeback over several cycles from one instruction register.
- Waits on a memory ready handshake and bounds each wait with a timeout.
- Drives datapath muxes and enables. Illegal opcodes and memory timeouts enter a sticky TRAP state.

Parameters:
- ALUOP_W, 2: width of alu_op (00 add, 01 sub/compare, 10 decode funct fields in ALU decoder).
- MEM_TIMEOUT, 15: maximum consecutive cycles waiting for mem_ready before TRAP; range 1..(2^CNT_W-1).
- CNT_W, 4: width of the wait counter.

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0] from the instruction register
- func3  in  3  instr[14:12]
- zero  in  1  ALU zero flag, valid in BRANCH state
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC register enable
- ir_write  out  1  instruction register enable
- adr_src  out  1  0 = PC, 1 = ALU result register
- mem_read  out  1  read request
- mem_write  out  1  write request
- reg_write  out  1  register file write enable
- alu_src_a  out  2  00 PC, 01 old PC, 10 rs1, 11 zero
- alu_src_b  out  2  00 rs2, 01 immediate, 10 constant 4
- alu_op  out  ALUOP_W  ALU decoder selector
- result_src  out  2  00 ALU result register, 01 memory data, 10 ALU out direct
- trap  out  1  sticky: illegal opcode or memory timeout
- busy  out  1  high in every state except FETCH and TRAP

Behaviour:
- Reset: next edge with reset=1 forces state to FETCH and clears the wait counter and trap.
  - All enables (pc_write, ir_write, mem_read, mem_write, reg_write) are 0 during reset.
  - All selects are 0 during reset.
  - Reset mid-instruction abandons the instruction; there is no partial writeback.
- Outputs are Moore-decoded from state. Exception: pc_write in FETCH and BRANCH is qualified combinationally by mem_ready / zero.
- States and transitions:
  - FETCH: mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00. Stays until mem_ready; on mem_ready, ir_write=1 and pc_write=1 (PC+4), then -> DECODE.
  - DECODE: computes branch/jump target (alu_src_a=01, alu_src_b=01).
    - load/store -> MEMADR
    - R_TYPE -> EXECR
    - I_TYPE -> EXECI
    - AUIPC/LUI -> EXECU
    - B_TYPE -> BRANCH
    - JAL -> JAL
    - JALR -> JALR
    - any other opcode -> TRAP
  - MEMADR: rs1+imm. Load -> MEMREAD; store -> MEMWRITE.
  - MEMREAD: mem_read=1, adr_src=1. Holds until mem_ready, then -> MEMWB.
  - MEMWB: reg_write=1, result_src=01 -> FETCH.
  - MEMWRITE: mem_write=1 held until mem_ready -> FETCH.
  - EXECR / EXECI / EXECU: alu_op=10 (EXECU: alu_src_a=01 for AUIPC, 11 for LUI) -> ALUWB.
  - ALUWB: reg_write=1, result_src=00 -> FETCH.
  - BRANCH: alu_op=01.
    - pc_write = zero for func3=000 (BEQ); pc_write = ~zero for func3=001 (BNE).
    - Any other func3 -> TRAP.
    - Otherwise -> FETCH.
  - JAL: pc_write=1 (target from DECODE); link via old PC+4 written in ALUWB -> ALUWB.
  - JALR: target rs1+imm, pc_write=1 -> ALUWB.
  - TRAP: all enables 0, trap=1; remains until reset.
- Wait counter:
  - Clears on entry to FETCH, MEMREAD or MEMWRITE.
  - Increments each waiting cycle.
  - Reaching MEM_TIMEOUT with mem_ready=0 -> TRAP.
  - If mem_ready arrives in the same cycle as the count reaching MEM_TIMEOUT, mem_ready wins.
- mem_ready outside memory states is ignored.
- Minimum latency with zero-wait memory: R/I/U = 4 cycles, load = 5, store = 4, branch = 3, jump = 4.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- Defined: adds output instret (32 bits), reset to 0.
  - Increments by 1 on every transition into FETCH from a completing state (MEMWB, MEMWRITE, ALUWB, BRANCH).
  - Wraps from 0xFFFFFFFF to 0.
  - Frozen in TRAP.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants (R_TYPE, I_TYPE, I_LOAD, S_TYPE, B_TYPE, AUIPC, LUI, JAL, JALR)
  - func3 constants (BEQ, BNE)
  - state enum (4-bit encoding)
  - alu_op and mux-select encodings
- One natural sub-module: mem_wait_timer (CNT_W counter with clear/enable, timeout flag compared against MEM_TIMEOUT).

Test Plan:
- ADD (opcode 0110011), mem_ready always 1 -> FETCH, DECODE, EXECR, ALUWB, FETCH; reg_write=1 exactly in cycle 4; pc_write only in cycle 1.
- LW with mem_ready low 3 cycles in MEMREAD -> mem_read held 4 cycles; MEMWB reg_write=1 with result_src=01; total 8 cycles.
- BEQ with zero=1 -> pc_write=1 in BRANCH. BNE with zero=1 -> pc_write=0. B_TYPE with func3=100 -> trap=1.
- Opcode 0000000 -> TRAP after DECODE; trap stays 1 for 20 cycles; reset=1 for one cycle -> FETCH, trap=0.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> TRAP after 15 wait cycles; mem_ready=1 on cycle 15 -> DECODE instead.
- With CTRL_PERF_CNT_EN: 3 ADDs + 1 SW -> instret=4; reset asserted mid-LW -> instret=0, no reg_write.
